// File: rtl/counter_arbiter.sv
// Round-robin arbiter that time-shares one counter between NUM_REQ requesters,
// sequencing each job through load, run and completion with a timeout guard.
module counter_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int WIDTH          = 4,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*WIDTH-1:0] cfg_init_i,
  input  logic [NUM_REQ*WIDTH-1:0] cfg_inc_i,
  input  logic [NUM_REQ*WIDTH-1:0] cfg_target_i,
  output logic [NUM_REQ-1:0]       grant_o,
  output logic [NUM_REQ-1:0]       done_o,
  output logic [WIDTH-1:0]         result_o,
  output logic                     err_o,
  output logic                     busy_o,
  output logic                     cnt_reset_o,
  output logic                     cnt_enable_o,
  output logic [WIDTH-1:0]         cnt_init_o,
  output logic [WIDTH-1:0]         cnt_inc_o,
  output logic [WIDTH-1:0]         cnt_target_o,
  input  logic [WIDTH-1:0]         cnt_value_i,
  input  logic                     cnt_done_i
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic                 cnt_reset_q, cnt_reset_d;
  logic                 cnt_enable_q, cnt_enable_d;
  logic [WIDTH-1:0]     cnt_init_q, cnt_init_d;
  logic [WIDTH-1:0]     cnt_inc_q, cnt_inc_d;
  logic [WIDTH-1:0]     cnt_target_q, cnt_target_d;

  logic                 found;
  logic [PW-1:0]        win_idx;
  logic [PW-1:0]        scan_idx;

  // Search upward from the requester after the last winner, wrapping around.
  always_comb begin
    found    = 1'b0;
    win_idx  = '0;
    scan_idx = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      scan_idx = PW'((int'(ptr_q) + i) % NUM_REQ);
      if (!found && req_i[scan_idx]) begin
        found   = 1'b1;
        win_idx = scan_idx;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    tmo_d        = tmo_q;
    grant_d      = grant_q;
    done_d       = done_q;
    result_d     = result_q;
    err_d        = err_q;
    busy_d       = busy_q;
    cnt_reset_d  = cnt_reset_q;
    cnt_enable_d = cnt_enable_q;
    cnt_init_d   = cnt_init_q;
    cnt_inc_d    = cnt_inc_q;
    cnt_target_d = cnt_target_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d      = LOAD;
          ptr_d        = win_idx;
          grant_d      = NUM_REQ'(1) << win_idx;
          busy_d       = 1'b1;
          cnt_reset_d  = 1'b1;
          cnt_init_d   = cfg_init_i[int'(win_idx)*WIDTH +: WIDTH];
          cnt_inc_d    = cfg_inc_i[int'(win_idx)*WIDTH +: WIDTH];
          cnt_target_d = cfg_target_i[int'(win_idx)*WIDTH +: WIDTH];
        end
      end
      LOAD: begin
        state_d      = RUN;
        cnt_reset_d  = 1'b0;
        cnt_enable_d = 1'b1;
      end
      RUN: begin
        tmo_d = tmo_q + TW'(1);
        // A genuine completion wins over a timeout landing on the same cycle.
        if (cnt_done_i || tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d      = DONE;
          result_d     = cnt_value_i;
          err_d        = !cnt_done_i;
          cnt_enable_d = 1'b0;
          done_d       = grant_q;
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = '0;
        done_d  = '0;
        busy_d  = 1'b0;
        tmo_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q      <= IDLE;
      ptr_q        <= PW'(NUM_REQ - 1);
      tmo_q        <= '0;
      grant_q      <= '0;
      done_q       <= '0;
      result_q     <= '0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      cnt_reset_q  <= 1'b0;
      cnt_enable_q <= 1'b0;
      cnt_init_q   <= '0;
      cnt_inc_q    <= '0;
      cnt_target_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      tmo_q        <= tmo_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      result_q     <= result_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      cnt_reset_q  <= cnt_reset_d;
      cnt_enable_q <= cnt_enable_d;
      cnt_init_q   <= cnt_init_d;
      cnt_inc_q    <= cnt_inc_d;
      cnt_target_q <= cnt_target_d;
    end
  end

  assign grant_o      = grant_q;
  assign done_o       = done_q;
  assign result_o     = result_q;
  assign err_o        = err_q;
  assign busy_o       = busy_q;
  assign cnt_reset_o  = cnt_reset_q;
  assign cnt_enable_o = cnt_enable_q;
  assign cnt_init_o   = cnt_init_q;
  assign cnt_inc_o    = cnt_inc_q;
  assign cnt_target_o = cnt_target_q;

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed bench for counter_arbiter with a behavioural counter attached;
// expected grants, results and job lengths are worked out by hand.
module tb_counter_arbiter;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req;
  logic [15:0] cfg_init;
  logic [15:0] cfg_inc;
  logic [15:0] cfg_target;
  logic [3:0]  grant_o;
  logic [3:0]  done_o;
  logic [3:0]  result_o;
  logic        err_o;
  logic        busy_o;
  logic        cnt_reset_o;
  logic        cnt_enable_o;
  logic [3:0]  cnt_init_o;
  logic [3:0]  cnt_inc_o;
  logic [3:0]  cnt_target_o;
  logic [3:0]  cnt_value;
  logic        cnt_done;

  int n_checks;
  int n_fails;

  counter_arbiter #(.NUM_REQ(4), .WIDTH(4), .TIMEOUT_CYCLES(32)) dut (
    .clk_i        (clk),
    .reset_i      (reset_n),
    .req_i        (req),
    .cfg_init_i   (cfg_init),
    .cfg_inc_i    (cfg_inc),
    .cfg_target_i (cfg_target),
    .grant_o      (grant_o),
    .done_o       (done_o),
    .result_o     (result_o),
    .err_o        (err_o),
    .busy_o       (busy_o),
    .cnt_reset_o  (cnt_reset_o),
    .cnt_enable_o (cnt_enable_o),
    .cnt_init_o   (cnt_init_o),
    .cnt_inc_o    (cnt_inc_o),
    .cnt_target_o (cnt_target_o),
    .cnt_value_i  (cnt_value),
    .cnt_done_i   (cnt_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the shared counter: load on reset, step while enabled, stop at target.
  assign cnt_done = (cnt_value == cnt_target_o);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt_value <= '0;
    else if (cnt_reset_o)
      cnt_value <= cnt_init_o;
    else if (cnt_enable_o && !cnt_done)
      cnt_value <= cnt_value + cnt_inc_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [15:0] init, input logic [15:0] inc,
                               input logic [15:0] target);
    req        = r;
    cfg_init   = init;
    cfg_inc    = inc;
    cfg_target = target;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_grant"}, grant_o, 0);
    checkOutput({tag, "_done"}, done_o, 0);
    checkOutput({tag, "_result"}, result_o, 0);
    checkOutput({tag, "_err"}, err_o, 0);
    checkOutput({tag, "_busy"}, busy_o, 0);
    checkOutput({tag, "_creset"}, cnt_reset_o, 0);
    checkOutput({tag, "_cen"}, cnt_enable_o, 0);
    checkOutput({tag, "_cinit"}, cnt_init_o, 0);
    checkOutput({tag, "_cinc"}, cnt_inc_o, 0);
    checkOutput({tag, "_ctgt"}, cnt_target_o, 0);
  endtask

  // Returns observing the LOAD cycle of the next job.
  task automatic waitGrant(input string tag, input logic [3:0] exp_grant, input logic [3:0] exp_init,
                           input logic [3:0] exp_inc, input logic [3:0] exp_tgt);
    int c = 0;
    while (grant_o == 4'b0000 && c < 20) begin
      tick();
      c++;
    end
    checkOutput({tag, "_grant"}, grant_o, exp_grant);
    checkOutput({tag, "_onehot"}, $countones(grant_o), 1);
    checkOutput({tag, "_load_reset"}, cnt_reset_o, 1);
    checkOutput({tag, "_load_en"}, cnt_enable_o, 0);
    checkOutput({tag, "_busy"}, busy_o, 1);
    checkOutput({tag, "_cinit"}, cnt_init_o, exp_init);
    checkOutput({tag, "_cinc"}, cnt_inc_o, exp_inc);
    checkOutput({tag, "_ctgt"}, cnt_target_o, exp_tgt);
  endtask

  // Waits for the done pulse, checks the captured result and the cycles taken,
  // then steps into the following IDLE cycle.
  task automatic waitDone(input string tag, input logic [3:0] exp_done, input logic [3:0] exp_result,
                          input logic exp_err, input bit drop, input int exp_len);
    int c = 0;
    while (done_o == 4'b0000 && c < 60) begin
      tick();
      c++;
    end
    checkOutput({tag, "_done"}, done_o, exp_done);
    checkOutput({tag, "_len"}, c, exp_len);
    checkOutput({tag, "_result"}, result_o, exp_result);
    checkOutput({tag, "_err"}, err_o, exp_err);
    checkOutput({tag, "_done_en"}, cnt_enable_o, 0);
    if (drop) req = req & ~exp_done;
    tick();
    checkOutput({tag, "_pulse_end"}, done_o, 0);
    checkOutput({tag, "_grant_clr"}, grant_o, 0);
    checkOutput({tag, "_idle_busy"}, busy_o, 0);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset_n  = 1'b0;
    applyStimulus(4'b0000, 16'h0000, 16'h0000, 16'h0000);
    repeat (3) tick();
    checkAllZero("rst");
    reset_n = 1'b1;
    tick();
    checkOutput("idle_noreq_busy", busy_o, 0);

    $display("[TB] single job on requester 0");
    applyStimulus(4'b0001, 16'h0000, 16'h0003, 16'h000F);
    waitGrant("t1", 4'b0001, 4'h0, 4'h3, 4'hF);
    tick();
    checkOutput("t1_run_reset", cnt_reset_o, 0);
    checkOutput("t1_run_en", cnt_enable_o, 1);
    waitDone("t1", 4'b0001, 4'hF, 1'b0, 1'b1, 6);

    $display("[TB] contention across all requesters");
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    applyStimulus(4'b1111, 16'h7152, 16'h0521, 16'h7B94);
    waitGrant("t2a", 4'b0001, 4'h2, 4'h1, 4'h4);
    waitDone("t2a", 4'b0001, 4'h4, 1'b0, 1'b0, 4);
    waitGrant("t2b", 4'b0010, 4'h5, 4'h2, 4'h9);
    waitDone("t2b", 4'b0010, 4'h9, 1'b0, 1'b1, 4);
    waitGrant("t2c", 4'b0100, 4'h1, 4'h5, 4'hB);
    waitDone("t2c", 4'b0100, 4'hB, 1'b0, 1'b1, 4);
    waitGrant("t2d", 4'b1000, 4'h7, 4'h0, 4'h7);
    waitDone("t2d", 4'b1000, 4'h7, 1'b0, 1'b1, 2);
    waitGrant("t2e", 4'b0001, 4'h2, 4'h1, 4'h4);
    waitDone("t2e", 4'b0001, 4'h4, 1'b0, 1'b1, 4);

    $display("[TB] fairness after immediate re-request");
    req = 4'b0001;
    waitGrant("t3a", 4'b0001, 4'h2, 4'h1, 4'h4);
    req = 4'b0101;
    waitDone("t3a", 4'b0001, 4'h4, 1'b0, 1'b0, 4);
    waitGrant("t3b", 4'b0100, 4'h1, 4'h5, 4'hB);
    waitDone("t3b", 4'b0100, 4'hB, 1'b0, 1'b1, 4);
    waitGrant("t3c", 4'b0001, 4'h2, 4'h1, 4'h4);
    waitDone("t3c", 4'b0001, 4'h4, 1'b0, 1'b1, 4);

    $display("[TB] timeout on a job that never finishes");
    applyStimulus(4'b0010, 16'h7102, 16'h0501, 16'h7BF4);
    waitGrant("t4a", 4'b0010, 4'h0, 4'h0, 4'hF);
    waitDone("t4a", 4'b0010, 4'h0, 1'b1, 1'b1, 33);
    checkOutput("t4_err_hold", err_o, 1);
    req = 4'b0001;
    waitGrant("t4b", 4'b0001, 4'h2, 4'h1, 4'h4);
    waitDone("t4b", 4'b0001, 4'h4, 1'b0, 1'b1, 4);

    $display("[TB] reset in the middle of a run");
    applyStimulus(4'b0001, 16'h7152, 16'h0521, 16'h7B94);
    waitGrant("t5a", 4'b0001, 4'h2, 4'h1, 4'h4);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    checkAllZero("t5_async");
    req = 4'b0110;
    repeat (2) tick();
    checkAllZero("t5_held");
    reset_n = 1'b1;
    waitGrant("t5b", 4'b0010, 4'h5, 4'h2, 4'h9);
    waitDone("t5b", 4'b0010, 4'h9, 1'b0, 1'b1, 4);
    waitGrant("t5c", 4'b0100, 4'h1, 4'h5, 4'hB);
    waitDone("t5c", 4'b0100, 4'hB, 1'b0, 1'b1, 4);

    $display("[TB] config change and request drop mid-job");
    applyStimulus(4'b1000, 16'h0152, 16'h3521, 16'hFB94);
    waitGrant("t6", 4'b1000, 4'h0, 4'h3, 4'hF);
    repeat (2) tick();
    applyStimulus(4'b0000, 16'h9999, 16'h1111, 16'h2222);
    tick();
    checkOutput("t6_cinit_kept", cnt_init_o, 4'h0);
    checkOutput("t6_cinc_kept", cnt_inc_o, 4'h3);
    checkOutput("t6_ctgt_kept", cnt_target_o, 4'hF);
    checkOutput("t6_grant_kept", grant_o, 4'b1000);
    waitDone("t6", 4'b1000, 4'hF, 1'b0, 1'b0, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
